// File: rtl/df_fir_sequencer_if.sv
// Bundle of sample, result, coefficient and shared-adder signals for df_fir_sequencer.
// Optional DF_SATURATE_EN adds the sticky sat_flag.
interface df_fir_sequencer_if #(
  parameter int TAPS = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [8:0]      in_data;
  logic [TAPS-1:0] coef_en;
  logic [TAPS-1:0] coef_sub;
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      out_data;
  logic            busy;
  logic [8:0]      add_a;
  logic [8:0]      add_b;
  logic            add_sub;
  logic [8:0]      add_out;
`ifdef DF_SATURATE_EN
  logic            sat_flag;
`endif

  // Sequencer side
  modport slave (
    input  in_valid, in_data, coef_en, coef_sub, out_ready, add_out,
    output in_ready, out_valid, out_data, busy, add_a, add_b, add_sub
`ifdef DF_SATURATE_EN
    , output sat_flag
`endif
  );

  // Sample source, result consumer and shared adder side
  modport master (
    output in_valid, in_data, coef_en, coef_sub, out_ready, add_out,
    input  in_ready, out_valid, out_data, busy, add_a, add_b, add_sub
`ifdef DF_SATURATE_EN
    , input sat_flag
`endif
  );
endinterface

// File: rtl/df_fir_sequencer.sv
// Time-multiplexed FIR/comb sequencer stepping one shared 9-bit adder/subtractor across TAPS taps.
// Optional macro DF_SATURATE_EN: clamp on signed overflow and expose sticky sat_flag.
module df_fir_sequencer #(
  parameter int TAPS = 4
) (
  input logic               clk,
  input logic               rst_n,
  df_fir_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(TAPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [8:0]      tap_r [TAPS];
  logic [8:0]      tap_s [TAPS];
  logic [8:0]      acc_r, acc_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [TAPS-1:0] en_r, en_s;
  logic [TAPS-1:0] sub_r, sub_s;
  logic            in_ready_r, in_ready_s;
  logic            out_valid_r, out_valid_s;
  logic [8:0]      out_data_r, out_data_s;
  logic            busy_r, busy_s;
  logic [8:0]      add_a_r, add_a_s;
  logic [8:0]      add_b_r, add_b_s;
  logic            add_sub_r, add_sub_s;
  logic            sat_r, sat_s;

`ifdef DF_SATURATE_EN
  function automatic logic ovf_detect(input logic [8:0] a, input logic [8:0] b,
                                      input logic [8:0] r, input logic sub);
    logic same_sign;
    same_sign = (a[8] == b[8]);
    if (sub) begin
      return !same_sign && (r[8] != a[8]);
    end else begin
      return same_sign && (r[8] != a[8]);
    end
  endfunction
`endif

  // Next-state, datapath update and next values of the registered outputs
  always_comb begin
    state_s = state_r;
    tap_s   = tap_r;
    acc_s   = acc_r;
    idx_s   = idx_r;
    en_s    = en_r;
    sub_s   = sub_r;
    sat_s   = sat_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          tap_s[0] = bus.in_data;
          for (int k = 1; k < TAPS; k++) begin
            tap_s[k] = tap_r[k-1];
          end
          en_s    = bus.coef_en;
          sub_s   = bus.coef_sub;
          acc_s   = 9'h000;
          idx_s   = '0;
          sat_s   = 1'b0;
          state_s = ST_ACC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (en_r[idx_r]) begin
`ifdef DF_SATURATE_EN
          // add_a_r mirrors acc_r throughout ACC, so its sign picks the clamp rail
          if (ovf_detect(add_a_r, add_b_r, bus.add_out, add_sub_r)) begin
            acc_s = add_a_r[8] ? 9'h100 : 9'h0FF;
            sat_s = 1'b1;
          end else begin
            acc_s = bus.add_out;
          end
`else
          acc_s = bus.add_out;
`endif
        end else begin
          acc_s = acc_r;
        end
        if (idx_r == IDX_W'(TAPS - 1)) begin
          state_s = ST_DONE;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    in_ready_s  = (state_s == ST_IDLE);
    out_valid_s = (state_s == ST_DONE);
    busy_s      = (state_s != ST_IDLE);
    if (state_s == ST_DONE) begin
      out_data_s = acc_s;
    end else begin
      out_data_s = out_data_r;
    end
    // Operands are presented one cycle ahead so the adder sees them as registered values
    if (state_s == ST_ACC) begin
      add_a_s   = acc_s;
      add_b_s   = tap_s[idx_s];
      add_sub_s = sub_s[idx_s];
    end else begin
      add_a_s   = 9'h000;
      add_b_s   = 9'h000;
      add_sub_s = 1'b0;
    end
  end

  // State, delay line and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      for (int k = 0; k < TAPS; k++) begin
        tap_r[k] <= 9'h000;
      end
      acc_r       <= 9'h000;
      idx_r       <= '0;
      en_r        <= '0;
      sub_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= 9'h000;
      busy_r      <= 1'b0;
      add_a_r     <= 9'h000;
      add_b_r     <= 9'h000;
      add_sub_r   <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      tap_r       <= tap_s;
      acc_r       <= acc_s;
      idx_r       <= idx_s;
      en_r        <= en_s;
      sub_r       <= sub_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      busy_r      <= busy_s;
      add_a_r     <= add_a_s;
      add_b_r     <= add_b_s;
      add_sub_r   <= add_sub_s;
      sat_r       <= sat_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.busy      = busy_r;
  assign bus.add_a     = add_a_r;
  assign bus.add_b     = add_b_r;
  assign bus.add_sub   = add_sub_r;
`ifdef DF_SATURATE_EN
  assign bus.sat_flag  = sat_r;
`else
  logic unused_sat_s;
  assign unused_sat_s = sat_r;
`endif
endmodule

// File: tb/tb_df_fir_sequencer.sv
// Scoreboard bench for df_fir_sequencer: directed samples push expected results, a negedge monitor checks them.
module tb_df_fir_sequencer;
  localparam int TAPS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   acc_cyc = 0;
  int   hs_cyc = 0;
  bit   lat_pending = 1'b0;
  logic [9:0] exp_q [$];

  df_fir_sequencer_if #(.TAPS(TAPS)) bus ();

  df_fir_sequencer #(.TAPS(TAPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural shared adder/subtractor, 9-bit wrap
  assign bus.add_out = bus.add_sub ? (bus.add_a - bus.add_b) : (bus.add_a + bus.add_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency, DONE-state outputs and result scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      lat_pending = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc = cyc + 1;
        lat_pending = 1'b1;
      end
      if (bus.out_valid) begin
        if (lat_pending) begin
          chk("latency", cyc + 1 - acc_cyc, TAPS + 1);
          lat_pending = 1'b0;
        end
        chk("in_ready_in_done", {31'd0, bus.in_ready}, 32'd0);
        chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          chk("out_data", {23'd0, bus.out_data}, {23'd0, exp_q[0][8:0]});
`ifdef DF_SATURATE_EN
          chk("sat_flag", {31'd0, bus.sat_flag}, {31'd0, exp_q[0][9]});
`endif
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            hs_cyc = cyc + 1;
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_out_data"}, {23'd0, bus.out_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_add_a"}, {23'd0, bus.add_a}, 32'd0);
    chk({tag, "_add_b"}, {23'd0, bus.add_b}, 32'd0);
    chk({tag, "_add_sub"}, {31'd0, bus.add_sub}, 32'd0);
`ifdef DF_SATURATE_EN
    chk({tag, "_sat_flag"}, {31'd0, bus.sat_flag}, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [8:0] d, input logic [8:0] e, input logic s, input bit push);
    if (push) exp_q.push_back({s, e});
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 9'h000;
    bus.coef_en   = 4'b1111;
    bus.coef_sub  = 4'b0000;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;

    // Plain running sum
    send(9'd1, 9'd1, 1'b0, 1'b1);
    send(9'd2, 9'd3, 1'b0, 1'b1);
    send(9'd3, 9'd6, 1'b0, 1'b1);
    send(9'd4, 9'd10, 1'b0, 1'b1);
    wait_idle();

    // Comb: tap 1 subtracted
    do_reset();
    bus.coef_sub = 4'b0010;
    send(9'd5, 9'd5, 1'b0, 1'b1);
    send(9'd7, 9'd2, 1'b0, 1'b1);
    wait_idle();

    // Overflow: wrap or clamp
    do_reset();
    bus.coef_en  = 4'b0011;
    bus.coef_sub = 4'b0000;
    send(9'd200, 9'd200, 1'b0, 1'b1);
`ifdef DF_SATURATE_EN
    send(9'd100, 9'h0FF, 1'b1, 1'b1);
`else
    send(9'd100, 9'h12C, 1'b0, 1'b1);
`endif
    wait_idle();

    // Backpressure with in_valid held high in DONE; line becomes [1,100,200,0] then [50,1,100,200]
    bus.coef_en   = 4'b1111;
    bus.out_ready = 1'b0;
`ifdef DF_SATURATE_EN
    send(9'd1, 9'h0FF, 1'b1, 1'b1);
    exp_q.push_back({1'b1, 9'h0FF});
`else
    send(9'd1, 9'h12D, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 9'h15F});
`endif
    bus.in_data  = 9'd50;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    chk("bp_reached_done", {31'd0, bus.out_valid}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_accept();
    chk("bp_accept_gap", acc_cyc, hs_cyc + 1);
    wait_idle();

    // Coefficient change mid-ACC is ignored
    do_reset();
    bus.coef_en  = 4'b1111;
    bus.coef_sub = 4'b0000;
    send(9'd10, 9'd10, 1'b0, 1'b1);
    wait_idle();
    send(9'd3, 9'd13, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.coef_sub = 4'b1111;
    wait_idle();
    bus.coef_sub = 4'b0000;

    // Reset during ACC at idx=2, line [20,3,10,0]
    send(9'd20, 9'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("acc_add_a", {23'd0, bus.add_a}, 32'd23);
    chk("acc_add_b", {23'd0, bus.add_b}, 32'd10);
    chk("acc_add_sub", {31'd0, bus.add_sub}, 32'd0);
    chk("acc_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midacc_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(9'd9, 9'd9, 1'b0, 1'b1);
    wait_idle();

    // All taps disabled
    bus.coef_en = 4'b0000;
    send(9'd77, 9'd0, 1'b0, 1'b1);
    wait_idle();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
